// File: rtl/silife_pkg.sv
// Shared types, rule constants and the neighbour-count helper for the silife_grid engine.
// SILIFE_STABLE_DETECT_EN makes the HALTED state reachable in silife_grid.
package silife_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } silife_state_t;

    typedef logic [8:0] silife_rule_t;

    // Classic Conway rule masks: bit n set means "n live neighbours qualifies".
    localparam silife_rule_t RULE_B3  = 9'b000001000;
    localparam silife_rule_t RULE_S23 = 9'b000001100;

    function automatic logic [3:0] count_live(input logic [7:0] nbrs);
        logic [3:0] total;
        total = 4'd0;
        for (int i = 0; i < 8; i++) begin
            total = total + {3'b000, nbrs[i]};
        end
        return total;
    endfunction

endpackage

// File: rtl/silife_rule_cell.sv
// One Game-of-Life cell: neighbour adder, birth/survive lookup and the state register.
// With SILIFE_STABLE_DETECT_EN the cell also reports whether its next state differs.
module silife_rule_cell
    import silife_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       update,
    input  logic       wr_hit,
    input  logic       wr_val,
    input  logic [7:0] neighbours,
    input  logic [8:0] birth_rule,
    input  logic [8:0] survive_rule,
`ifdef SILIFE_STABLE_DETECT_EN
    output logic       changed,
`endif
    output logic       alive
);

    silife_rule_t rule_sel;
    logic [3:0]   live_count;
    logic         next_alive;

    // A live cell consults the survive mask, a dead one the birth mask.
    always_comb begin
        live_count = count_live(neighbours);
        rule_sel   = alive ? survive_rule : birth_rule;
        next_alive = rule_sel[live_count];
    end

`ifdef SILIFE_STABLE_DETECT_EN
    assign changed = next_alive ^ alive;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alive <= 1'b0;
        end else if (clear) begin
            alive <= 1'b0;
        end else if (wr_hit) begin
            alive <= wr_val;
        end else if (update) begin
            alive <= next_alive;
        end
    end

endmodule

// File: rtl/silife_grid.sv
// Parametrised Game-of-Life grid: cell array, toroidal/dead-edge wiring, run/step FSM and counter.
// SILIFE_STABLE_DETECT_EN adds the stable flag and the HALTED state.
module silife_grid
    import silife_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8,
    parameter int GEN_W  = 16
)
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       run,
    input  logic                       step,
    input  logic                       tick,
    input  logic                       wrap,
    input  logic [8:0]                 birth_rule,
    input  logic [8:0]                 survive_rule,
    input  logic                       clear_all,
    input  logic                       wr_en,
    input  logic [$clog2(HEIGHT)-1:0]  wr_row,
    input  logic [$clog2(WIDTH)-1:0]   wr_col,
    input  logic                       wr_val,
    output logic [HEIGHT*WIDTH-1:0]    cells,
    output logic [GEN_W-1:0]           generation,
    output logic                       gen_done,
    output logic                       stable
);

    localparam int ROW_W = $clog2(HEIGHT);
    localparam int COL_W = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE   = ST_IDLE;
    localparam logic [1:0] S_RUN    = ST_RUN;
`ifdef SILIFE_STABLE_DETECT_EN
    localparam logic [1:0] S_HALTED = ST_HALTED;
`endif

    logic [1:0]              state;
    logic [1:0]              state_next;
    logic                    gen_fire;
    logic [HEIGHT*WIDTH-1:0] cell_bits;
`ifdef SILIFE_STABLE_DETECT_EN
    logic [HEIGHT*WIDTH-1:0] change_bits;
`endif

    // Neighbour k runs over the 3x3 window in raster order, skipping the centre.
    // Off-grid neighbours fold onto the opposite edge and are gated by wrap.
    for (genvar gy = 0; gy < HEIGHT; gy++) begin : g_row
        for (genvar gx = 0; gx < WIDTH; gx++) begin : g_col
            localparam int CELL = gy * WIDTH + gx;
            logic [7:0] nbrs;

            for (genvar gk = 0; gk < 8; gk++) begin : g_nbr
                localparam int K      = (gk < 4) ? gk : gk + 1;
                localparam int NY     = gy + (K / 3) - 1;
                localparam int NX     = gx + (K % 3) - 1;
                localparam bit INSIDE = (NY >= 0) && (NY < HEIGHT) && (NX >= 0) && (NX < WIDTH);
                localparam int WY     = (NY + HEIGHT) % HEIGHT;
                localparam int WX     = (NX + WIDTH) % WIDTH;
                localparam int IDX    = WY * WIDTH + WX;
                if (INSIDE) begin : g_in
                    assign nbrs[gk] = cell_bits[IDX];
                end else begin : g_edge
                    assign nbrs[gk] = wrap & cell_bits[IDX];
                end
            end

            silife_rule_cell u_cell (
                .clk          (clk),
                .reset        (reset),
                .clear        (clear_all),
                .update       (gen_fire),
                .wr_hit       (wr_en && (wr_row == ROW_W'(gy)) && (wr_col == COL_W'(gx))),
                .wr_val       (wr_val),
                .neighbours   (nbrs),
                .birth_rule   (birth_rule),
                .survive_rule (survive_rule),
`ifdef SILIFE_STABLE_DETECT_EN
                .changed      (change_bits[CELL]),
`endif
                .alive        (cell_bits[CELL])
            );
        end
    end

    assign cells = cell_bits;

    // clear_all wins over any generation that would otherwise happen this cycle.
    always_comb begin
        gen_fire = 1'b0;
        if (!clear_all) begin
            if (state == S_IDLE) begin
                gen_fire = step && !run;
            end else if (state == S_RUN) begin
                gen_fire = tick;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (run) state_next = S_RUN;
            end
            S_RUN: begin
                if (!run) state_next = S_IDLE;
`ifdef SILIFE_STABLE_DETECT_EN
                else if (gen_fire && !wr_en && !(|change_bits)) state_next = S_HALTED;
`endif
            end
`ifdef SILIFE_STABLE_DETECT_EN
            S_HALTED: begin
                if (!run) state_next = S_IDLE;
            end
`endif
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            generation <= '0;
            gen_done   <= 1'b0;
        end else begin
            state    <= state_next;
            gen_done <= gen_fire;
            if (clear_all) begin
                generation <= '0;
            end else if (gen_fire) begin
                generation <= generation + GEN_W'(1);
            end
        end
    end

`ifdef SILIFE_STABLE_DETECT_EN
    // A write in the same cycle perturbs the grid, so it never counts as stable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable <= 1'b0;
        end else if (clear_all || wr_en) begin
            stable <= 1'b0;
        end else if (gen_fire) begin
            stable <= ~(|change_bits);
        end
    end
`else
    assign stable = 1'b0;
`endif

endmodule

// File: tb/tb_silife_grid.sv
// Directed bench for silife_grid: an 8x8/GEN_W=16 instance and a 5x5/GEN_W=4 instance on shared inputs.
// Checks stable/HALTED behaviour when SILIFE_STABLE_DETECT_EN is defined.
module tb_silife_grid;
    import silife_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        run, step, tick, wrap;
    logic [8:0]  birth_rule, survive_rule;
    logic        clear_all, wr_en, wr_val;
    logic [2:0]  wr_row, wr_col;

    logic [63:0] cells_big;
    logic [15:0] gen_big;
    logic        done_big, stable_big;
    logic [24:0] cells_small;
    logic [3:0]  gen_small;
    logic        done_small, stable_small;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    silife_grid #(.WIDTH(8), .HEIGHT(8), .GEN_W(16)) dut (
        .clk(clk), .reset(reset), .run(run), .step(step), .tick(tick), .wrap(wrap),
        .birth_rule(birth_rule), .survive_rule(survive_rule), .clear_all(clear_all),
        .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_val(wr_val),
        .cells(cells_big), .generation(gen_big), .gen_done(done_big), .stable(stable_big)
    );

    silife_grid #(.WIDTH(5), .HEIGHT(5), .GEN_W(4)) dut_small (
        .clk(clk), .reset(reset), .run(run), .step(step), .tick(tick), .wrap(wrap),
        .birth_rule(birth_rule), .survive_rule(survive_rule), .clear_all(clear_all),
        .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_val(wr_val),
        .cells(cells_small), .generation(gen_small), .gen_done(done_small), .stable(stable_small)
    );

    typedef struct {
        string       name;
        logic [63:0] init;
        logic [8:0]  birth;
        logic [8:0]  survive;
        logic        wrap;
        logic [63:0] expected;
    } vec_t;

    vec_t vecs[13];

    function automatic logic [63:0] b8(input int r, input int c);
        logic [63:0] one;
        one = 64'd1;
        return one << (r * 8 + c);
    endfunction

    function automatic logic [24:0] s5(input int r, input int c);
        logic [24:0] one;
        one = 25'd1;
        return one << (r * 5 + c);
    endfunction

    task automatic tick_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic write_cell(input int r, input int c, input logic v);
        wr_en  = 1'b1;
        wr_row = 3'(r);
        wr_col = 3'(c);
        wr_val = v;
        tick_clock();
        wr_en  = 1'b0;
    endtask

    task automatic load_pattern(input logic [63:0] pat);
        clear_all = 1'b1;
        tick_clock();
        clear_all = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (pat[i]) write_cell(i / 8, i % 8, 1'b1);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        birth_rule   = v.birth;
        survive_rule = v.survive;
        wrap         = v.wrap;
        load_pattern(v.init);
        step = 1'b1;
        tick_clock();
        step = 1'b0;
        check_output({v.name, ".cells"}, cells_big, v.expected);
        check_output({v.name, ".gen"}, 64'(gen_big), 64'd1);
        check_output({v.name, ".done"}, 64'(done_big), 64'd1);
        tick_clock();
        check_output({v.name, ".done_low"}, 64'(done_big), 64'd0);
    endtask

    logic [63:0] ring, glider, blinker_h;

    initial begin
        reset = 1'b1; run = 1'b0; step = 1'b0; tick = 1'b0; wrap = 1'b0;
        birth_rule = RULE_B3; survive_rule = RULE_S23;
        clear_all = 1'b0; wr_en = 1'b0; wr_row = 3'd0; wr_col = 3'd0; wr_val = 1'b0;

        ring      = b8(3,3) | b8(3,4) | b8(3,5) | b8(5,3) | b8(5,4) | b8(5,5);
        glider    = b8(0,1) | b8(1,2) | b8(2,0) | b8(2,1) | b8(2,2);
        blinker_h = b8(3,2) | b8(3,3) | b8(3,4);

        vecs[0]  = '{"blinker",       blinker_h, RULE_B3, RULE_S23, 1'b0, b8(2,3) | b8(3,3) | b8(4,3)};
        vecs[1]  = '{"block",         b8(1,1) | b8(1,2) | b8(2,1) | b8(2,2), RULE_B3, RULE_S23, 1'b0,
                     b8(1,1) | b8(1,2) | b8(2,1) | b8(2,2)};
        vecs[2]  = '{"lonely",        b8(4,4), RULE_B3, RULE_S23, 1'b0, 64'd0};
        vecs[3]  = '{"highlife",      ring, 9'b001001000, RULE_S23, 1'b0,
                     b8(2,4) | b8(3,4) | b8(4,4) | b8(5,4) | b8(6,4)};
        vecs[4]  = '{"conway6",       ring, RULE_B3, RULE_S23, 1'b0, b8(2,4) | b8(3,4) | b8(5,4) | b8(6,4)};
        vecs[5]  = '{"wrap_row",      b8(0,7) | b8(0,0) | b8(0,1), RULE_B3, RULE_S23, 1'b1,
                     b8(7,0) | b8(0,0) | b8(1,0)};
        vecs[6]  = '{"nowrap_row",    b8(0,7) | b8(0,0) | b8(0,1), RULE_B3, RULE_S23, 1'b0, 64'd0};
        vecs[7]  = '{"wrap_col",      b8(7,5) | b8(0,5) | b8(1,5), RULE_B3, RULE_S23, 1'b1,
                     b8(0,4) | b8(0,5) | b8(0,6)};
        vecs[8]  = '{"wrap_corner",   b8(0,0) | b8(0,7) | b8(7,0) | b8(7,7), RULE_B3, RULE_S23, 1'b1,
                     b8(0,0) | b8(0,7) | b8(7,0) | b8(7,7)};
        vecs[9]  = '{"nowrap_corner", b8(0,0) | b8(0,7) | b8(7,0) | b8(7,7), RULE_B3, RULE_S23, 1'b0, 64'd0};
        vecs[10] = '{"birth0",        64'd0, 9'b000000001, 9'b000000000, 1'b0, {64{1'b1}}};
        vecs[11] = '{"survive8",      {64{1'b1}}, 9'b000000000, 9'b100000000, 1'b0, 64'h007E7E7E7E7E7E00};
        vecs[12] = '{"survive8_wrap", {64{1'b1}}, 9'b000000000, 9'b100000000, 1'b1, {64{1'b1}}};

        repeat (3) tick_clock();
        check_output("reset.cells", cells_big, 64'd0);
        check_output("reset.gen", 64'(gen_big), 64'd0);
        check_output("reset.done", 64'(done_big), 64'd0);
        check_output("reset.stable", 64'(stable_big), 64'd0);
        check_output("reset.small_cells", 64'(cells_small), 64'd0);
        reset = 1'b0;
        tick_clock();

        for (int i = 0; i < 13; i++) apply_stimulus(vecs[i]);

        // Writes beyond a 5x5 grid must be dropped by the small instance.
        birth_rule = RULE_B3; survive_rule = RULE_S23; wrap = 1'b0;
        load_pattern(b8(6,1) | b8(1,6) | b8(4,4));
        check_output("oob.small", 64'(cells_small), 64'(s5(4,4)));
        check_output("oob.big", cells_big, b8(6,1) | b8(1,6) | b8(4,4));

        load_pattern(b8(2,1) | b8(2,2) | b8(2,3));
        step = 1'b1; tick_clock(); step = 1'b0;
        check_output("blink5.cells1", 64'(cells_small), 64'(s5(1,2) | s5(2,2) | s5(3,2)));
        check_output("blink5.gen1", 64'(gen_small), 64'd1);
        check_output("blink5.done", 64'(done_small), 64'd1);
        tick_clock();
        check_output("blink5.done_low", 64'(done_small), 64'd0);
        step = 1'b1; tick_clock(); step = 1'b0;
        check_output("blink5.cells2", 64'(cells_small), 64'(s5(2,1) | s5(2,2) | s5(2,3)));
        check_output("blink5.gen2", 64'(gen_small), 64'd2);

        wrap = 1'b1;
        load_pattern(glider);
        run = 1'b1; tick_clock();
        tick = 1'b1;
        repeat (4) tick_clock();
        check_output("glider.shift4", cells_big, b8(1,2) | b8(2,3) | b8(3,1) | b8(3,2) | b8(3,3));
        repeat (28) tick_clock();
        tick = 1'b0; run = 1'b0; tick_clock();
        check_output("glider.cells32", cells_big, glider);
        check_output("glider.gen32", 64'(gen_big), 64'd32);

        wrap = 1'b0;
        load_pattern(blinker_h);
        run = 1'b1; tick_clock();
        step = 1'b1; tick_clock(); step = 1'b0;
        check_output("run.step_ignored", 64'(done_big), 64'd0);
        tick = 1'b1; wr_en = 1'b1; wr_row = 3'd2; wr_col = 3'd3; wr_val = 1'b0;
        tick_clock();
        check_output("collide.cells", cells_big, b8(3,3) | b8(4,3));
        check_output("collide.gen", 64'(gen_big), 64'd1);
        check_output("collide.done", 64'(done_big), 64'd1);
        wr_row = 3'd0; wr_col = 3'd0; wr_val = 1'b1;
        tick_clock();
        wr_en = 1'b0;
        check_output("collide2.cells", cells_big, b8(0,0));
        check_output("collide2.gen", 64'(gen_big), 64'd2);
        clear_all = 1'b1;
        tick_clock();
        clear_all = 1'b0; tick = 1'b0;
        check_output("clear.cells", cells_big, 64'd0);
        check_output("clear.gen", 64'(gen_big), 64'd0);
        check_output("clear.done", 64'(done_big), 64'd0);
        run = 1'b0; tick_clock();

        load_pattern(blinker_h);
        run = 1'b1; tick_clock();
        for (int i = 0; i < 12; i++) begin
            tick = (i % 4 == 3);
            tick_clock();
            check_output($sformatf("pace.done%0d", i), 64'(done_big), 64'(i % 4 == 3));
        end
        tick = 1'b0; run = 1'b0; tick_clock();
        check_output("pace.gen", 64'(gen_big), 64'd3);
        check_output("pace.cells", cells_big, b8(2,3) | b8(3,3) | b8(4,3));

        load_pattern(b8(2,1) | b8(2,2) | b8(2,3));
        run = 1'b1; tick_clock();
        tick = 1'b1;
        repeat (15) tick_clock();
        check_output("cnt.small15", 64'(gen_small), 64'd15);
        tick_clock();
        check_output("cnt.small_wrap", 64'(gen_small), 64'd0);
        check_output("cnt.small_done", 64'(done_small), 64'd1);
        check_output("cnt.big16", 64'(gen_big), 64'd16);
        tick = 1'b0; run = 1'b0; tick_clock();

        load_pattern(blinker_h);
        run = 1'b1; tick_clock();
        tick = 1'b1; tick_clock(); tick_clock();
        #3 reset = 1'b1;
        #1;
        check_output("areset.cells", cells_big, 64'd0);
        check_output("areset.gen", 64'(gen_big), 64'd0);
        check_output("areset.done", 64'(done_big), 64'd0);
        tick_clock();
        reset = 1'b0; run = 1'b0;
        write_cell(3, 3, 1'b1);
        tick_clock(); tick_clock();
        check_output("areset.idle_cells", cells_big, b8(3,3));
        check_output("areset.idle_gen", 64'(gen_big), 64'd0);
        tick = 1'b0;

        load_pattern(b8(1,1) | b8(1,2) | b8(2,1) | b8(2,2));
        run = 1'b1; tick_clock();
        tick = 1'b1; tick_clock();
`ifdef SILIFE_STABLE_DETECT_EN
        check_output("stable.flag", 64'(stable_big), 64'd1);
        check_output("stable.gen1", 64'(gen_big), 64'd1);
        tick_clock(); tick_clock();
        check_output("halted.gen_frozen", 64'(gen_big), 64'd1);
        check_output("halted.done_low", 64'(done_big), 64'd0);
        tick = 1'b0; run = 1'b0; tick_clock();
        step = 1'b1; tick_clock(); step = 1'b0;
        check_output("halted.to_idle_step", 64'(gen_big), 64'd2);
        write_cell(6, 6, 1'b1);
        check_output("stable.write_clears", 64'(stable_big), 64'd0);
`else
        check_output("stable.tied_low", 64'(stable_big), 64'd0);
        tick_clock(); tick_clock();
        check_output("block.gen_runs", 64'(gen_big), 64'd3);
        check_output("block.cells", cells_big, b8(1,1) | b8(1,2) | b8(2,1) | b8(2,2));
        tick = 1'b0; run = 1'b0; tick_clock();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
